fx2_cmd_dispatcher: RTL and testbench

Reads framed command bytes from the FX2 host-to-device FIFO and delivers each payload byte to one of `N_TARGETS` strobe-bit consumers. Each consumer is selected by a one-hot mask bit and returns a one-cycle-late data acknowledge. The block sits between the FX2 FIFO read port and the per-function strobe/register controllers, so that one shared command byte stream serves many destinations. Malformed frames and non-responding targets are detected and reported with sticky flags.

---
 rtl/fx2_dispatch_pkg.sv | 12 +
 rtl/dispatch_ack_timer.sv | 22 ++
 rtl/fx2_cmd_dispatcher.sv | 118 +++++++++++
 tb/tb_fx2_cmd_dispatcher.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_dispatch_pkg.sv
// fx2_dispatch_pkg: shared state encoding, header field layout and length decode for fx2_cmd_dispatcher
package fx2_dispatch_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, STROBE, ACK, DISCARD} state_e;
  localparam int HDR_IDX_MSB = 7;
  localparam int HDR_IDX_LSB = 4;
  localparam int HDR_LEN_MSB = 3;
  localparam int HDR_LEN_LSB = 0;
  localparam int LEN_ZERO_VALUE = 16;
  function automatic logic [4:0] hdr_len(input logic [7:0] hdr);
    return (hdr[HDR_LEN_MSB:HDR_LEN_LSB] == 4'd0) ? 5'(LEN_ZERO_VALUE) : {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]};
  endfunction
endpackage

// File: rtl/dispatch_ack_timer.sv
// dispatch_ack_timer: counts un-acked ACK cycles and flags expiry (only built with DISPATCH_TIMEOUT_EN)
// Ports: clk, reset (sync, active-high), clr (hold count at 0), en (count this cycle), expire (en on the ACK_TIMEOUT-th counted cycle)
`ifdef DISPATCH_TIMEOUT_EN
module dispatch_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
  // cnt_q holds the number of earlier un-acked ACK cycles, so this fires on the ACK_TIMEOUT-th one
  assign expire = en && (cnt_q == 8'(ACK_TIMEOUT - 1));
endmodule
`endif

// File: rtl/fx2_cmd_dispatcher.sv
// fx2_cmd_dispatcher: parses framed bytes from the FX2 FIFO and strobes each payload byte to a one-hot target
// Ports: clk, reset (sync, active-high); FIFO read side fifo_data/fifo_empty/fifo_rd;
//   target side tgt_mask/tgt_data/tgt_ack; status busy, err_bad_tgt, err_timeout, err_clr, frame_cnt.
// Optional feature macro: DISPATCH_TIMEOUT_EN (ack timeout via dispatch_ack_timer; otherwise ACK waits forever).
module fx2_cmd_dispatcher
  import fx2_dispatch_pkg::*;
#(
  parameter int N_TARGETS   = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  output logic [N_TARGETS-1:0] tgt_mask,
  output logic [7:0]           tgt_data,
  input  logic [N_TARGETS-1:0] tgt_ack,
  output logic                 busy,
  output logic                 err_bad_tgt,
  output logic                 err_timeout,
  input  logic                 err_clr,
  output logic [15:0]          frame_cnt
);
  if (N_TARGETS < 1 || N_TARGETS > 16 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_cfg
    $error("fx2_cmd_dispatcher: parameter out of range");
  end
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] rem_q, rem_d;
  logic [7:0] data_q, data_d;
  logic err_bad_q, err_bad_d, err_to_q, err_to_d;
  logic [15:0] cnt_q, cnt_d;
  logic [N_TARGETS-1:0] sel;
  logic ack_hit, expire, idx_ok, last;
  assign sel     = N_TARGETS'(1) << idx_q;
  assign ack_hit = |(tgt_ack & sel);
  assign idx_ok  = {1'b0, fifo_data[HDR_IDX_MSB:HDR_IDX_LSB]} < 5'(N_TARGETS);
  assign last    = rem_q == 5'd1;
`ifdef DISPATCH_TIMEOUT_EN
  dispatch_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(state_q != ACK),
    .en(state_q == ACK && !ack_hit),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      rem_q     <= 5'd0;
      data_q    <= 8'h00;
      err_bad_q <= 1'b0;
      err_to_q  <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      err_bad_q <= err_bad_d;
      err_to_q  <= err_to_d;
      cnt_q     <= cnt_d;
    end
  end
  // new errors are assigned after the clear default, so they win over err_clr
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_bad_d = err_clr ? 1'b0 : err_bad_q;
    err_to_d  = err_clr ? 1'b0 : err_to_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        idx_d   = fifo_data[HDR_IDX_MSB:HDR_IDX_LSB];
        rem_d   = hdr_len(fifo_data);
        state_d = idx_ok ? FETCH : DISCARD;
        if (!idx_ok) err_bad_d = 1'b1;
      end
      FETCH: if (!fifo_empty) begin
        data_d  = fifo_data;
        state_d = STROBE;
      end
      STROBE: state_d = ACK;
      ACK: if (ack_hit) begin
        rem_d   = rem_q - 5'd1;
        state_d = last ? IDLE : FETCH;
        if (last) cnt_d = cnt_q + 16'd1;
      end else if (expire) begin
        // the un-acked byte is abandoned; only the bytes still in the FIFO need discarding
        err_to_d = 1'b1;
        rem_d    = rem_q - 5'd1;
        state_d  = last ? IDLE : DISCARD;
      end
      DISCARD: if (!fifo_empty) begin
        rem_d = rem_q - 5'd1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // reset gates the combinational pop and strobe so a mid-frame reset has no side effect in its own cycle
  always_comb begin
    fifo_rd  = !reset && !fifo_empty && (state_q == IDLE || state_q == FETCH || state_q == DISCARD);
    tgt_mask = (!reset && state_q == STROBE) ? sel : '0;
  end
  assign busy        = state_q != IDLE;
  assign tgt_data    = data_q;
  assign err_bad_tgt = err_bad_q;
  assign err_timeout = err_to_q;
  assign frame_cnt   = cnt_q;
endmodule

// File: tb/tb_fx2_cmd_dispatcher.sv
// tb_fx2_cmd_dispatcher: directed and randomized checks of fx2_cmd_dispatcher against a frame-level model
module tb_fx2_cmd_dispatcher;
  logic clk = 1'b0;
  logic reset, fifo_empty, fifo_rd, busy, err_bad_tgt, err_timeout, err_clr;
  logic [7:0] fifo_data, tgt_data;
  logic [3:0] tgt_mask, tgt_ack;
  logic [15:0] frame_cnt;
  typedef struct {int t; logic [7:0] d;} dlv_t;
  logic [7:0] fifo_q[$];
  logic [7:0] pl_q[$];
  dlv_t exp_q[$];
  int sc_q[$];
  int checks = 0, errors = 0, cyc = 0, rd_cnt = 0, hdr_cyc = 0, fall_cyc = 0, exp_frames = 0;
  logic exp_bad = 1'b0;
  bit resp_en = 1'b1, noise = 1'b0, pend = 1'b0, prev_busy = 1'b0;
  int dmax = 0, stall_pct = 0, dly = 0;
  logic [3:0] cur = 4'd0, prev_mask = 4'd0;
  fx2_cmd_dispatcher #(.N_TARGETS(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .tgt_mask(tgt_mask), .tgt_data(tgt_data), .tgt_ack(tgt_ack), .busy(busy),
    .err_bad_tgt(err_bad_tgt), .err_timeout(err_timeout), .err_clr(err_clr), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  // one clock: FIFO pop and target responses just after the edge, monitor checks on the falling edge
  task automatic tick();
    logic rd_s;
    logic [3:0] ms, nz;
    dlv_t e;
    @(posedge clk);
    rd_s = fifo_rd;
    ms = tgt_mask;
    #1;
    if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    nz = noise ? 4'($urandom) : 4'd0;
    if (!resp_en || reset) pend = 1'b0;
    else if (ms != 4'd0) begin
      pend = 1'b1;
      cur = ms;
      dly = $urandom_range(0, dmax);
    end
    if (resp_en) begin
      if (pend && dly == 0) begin
        tgt_ack = cur | (nz & ~cur);
        pend = 1'b0;
      end else begin
        tgt_ack = pend ? (nz & ~cur) : nz;
        if (pend) dly--;
      end
    end
    fifo_empty = (fifo_q.size() == 0) || ($urandom_range(0, 99) < stall_pct);
    fifo_data = fifo_empty ? 8'h00 : fifo_q[0];
    @(negedge clk);
    cyc++;
    if (fifo_rd) begin
      chk("rd_while_empty", fifo_empty, 0);
      rd_cnt++;
      if (!busy) hdr_cyc = cyc;
    end
    if (tgt_mask != 4'd0) begin
      chk("mask_isolated", prev_mask, 0);
      sc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_strobe", tgt_mask, 0);
      else begin
        e = exp_q.pop_front();
        chk("strobe_mask", tgt_mask, 4'(1) << e.t);
        chk("strobe_data", tgt_data, e.d);
      end
    end
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
    prev_mask = tgt_mask;
  endtask
  // frame-level model: header then pl_q payload; valid index yields deliveries and a completed frame
  task automatic send_frame(input logic [7:0] hdr);
    int idx;
    idx = int'(hdr[7:4]);
    fifo_q.push_back(hdr);
    for (int i = 0; i < pl_q.size(); i++) begin
      fifo_q.push_back(pl_q[i]);
      if (idx < 4) exp_q.push_back('{t: idx, d: pl_q[i]});
    end
    pl_q.delete();
    if (idx < 4) exp_frames++;
    else exp_bad = 1'b1;
  endtask
  task automatic fill_rand(input logic [7:0] hdr);
    int n;
    n = (hdr[3:0] == 4'd0) ? 16 : int'(hdr[3:0]);
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask
  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((fifo_q.size() != 0 || busy) && n < limit);
    chk("idle_wait_expired", (fifo_q.size() != 0 || busy), 0);
    chk("deliveries_outstanding", exp_q.size(), 0);
  endtask
  task automatic wait_strobe(input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (tgt_mask == 4'd0 && n < limit);
    chk("strobe_wait_expired", tgt_mask != 4'd0, 1);
  endtask
  initial begin
    logic [7:0] h;
    int rd0, fc;
    reset = 1'b1; err_clr = 1'b0; tgt_ack = 4'd0; fifo_empty = 1'b1; fifo_data = 8'h00;
    tick();
    tick();
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_mask", tgt_mask, 0);
    chk("rst_data", tgt_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_bad", err_bad_tgt, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    reset = 1'b0;
    // two-byte frame to target 1, prompt acks
    sc_q.delete();
    rd0 = rd_cnt;
    pl_q = '{8'hAA, 8'hBB};
    send_frame(8'h12);
    wait_idle(200);
    chk("t1_strobes", sc_q.size(), 2);
    chk("t1_hdr_to_strobe", sc_q[0] - hdr_cyc, 2);
    chk("t1_byte_period", sc_q[1] - sc_q[0], 3);
    chk("t1_busy_fall", fall_cyc - sc_q[1], 2);
    chk("t1_rd_pulses", rd_cnt - rd0, 3);
    chk("t1_frame_cnt", frame_cnt, 1);
    // bad index with a 16-byte body, then a 1-byte frame to target 0
    fill_rand(8'h70);
    send_frame(8'h70);
    pl_q = '{8'h55};
    send_frame(8'h01);
    wait_idle(400);
    chk("t2_err_bad", err_bad_tgt, 1);
    chk("t2_frame_cnt", frame_cnt, 2);
    chk("t2_1byte_frame_cycles", fall_cyc - hdr_cyc, 4);
    // err_clr alone, then err_clr coinciding with a new bad header
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err_bad", err_bad_tgt, 0);
    pl_q = '{8'h9E};
    send_frame(8'hF1);
    tick();
    chk("clr_race_hdr_pop", fifo_rd && !busy, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_wins_over_clr", err_bad_tgt, 1);
    wait_idle(100);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err_bad_again", err_bad_tgt, 0);
    exp_bad = 1'b0;
    // payload byte arrives late: stays in FETCH without popping
    fifo_q.push_back(8'h21);
    exp_q.push_back('{t: 2, d: 8'h3C});
    exp_frames++;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_rd", fifo_rd, 0);
      chk("stall_busy", busy, 1);
    end
    fifo_q.push_back(8'h3C);
    tick();
    chk("stall_pop", fifo_rd, 1);
    tick();
    chk("stall_strobe", tgt_mask, 4'b0100);
    wait_idle(100);
    chk("stall_frame_cnt", frame_cnt, 16'(exp_frames));
    // wrong-target ack and an ack during STROBE are both ignored
    resp_en = 1'b0;
    tgt_ack = 4'd0;
    pl_q = '{8'h77};
    send_frame(8'h11);
    wait_strobe(20);
    tgt_ack = 4'b0010;
    tick();
    tgt_ack = 4'b1000;
    fc = int'(frame_cnt);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrong_ack_busy", busy, 1);
      chk("wrong_ack_frame_cnt", frame_cnt, fc);
    end
    tgt_ack = 4'b0010;
    tick();
    tgt_ack = 4'd0;
    chk("right_ack_idle", busy, 0);
    chk("right_ack_frame_cnt", frame_cnt, fc + 1);
    chk("right_ack_drained", exp_q.size(), 0);
`ifdef DISPATCH_TIMEOUT_EN
    // target 0 never acks: one strobe, timeout after 15 ACK cycles, 2 bytes discarded
    h = 8'($urandom);
    fifo_q.push_back(8'h03);
    fifo_q.push_back(h);
    fifo_q.push_back(8'($urandom));
    fifo_q.push_back(8'($urandom));
    exp_q.push_back('{t: 0, d: h});
    fc = int'(frame_cnt);
    wait_strobe(20);
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", err_timeout, 0);
    tick();
    chk("to_set", err_timeout, 1);
    chk("to_discarding", busy, 1);
    wait_idle(100);
    chk("to_frame_cnt", frame_cnt, fc);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", err_timeout, 0);
`endif
    // reset while waiting for an ack; leftover bytes 0x31,0x99 then form a frame to target 3
    fifo_q.push_back(8'h13);
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h31);
    fifo_q.push_back(8'h99);
    exp_q.push_back('{t: 1, d: 8'h5A});
    wait_strobe(20);
    tick();
    reset = 1'b1;
    chk("rst_mid_no_rd", fifo_rd, 0);
    tick();
    chk("rst_mid_mask", tgt_mask, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_frame_cnt", frame_cnt, 0);
    chk("rst_mid_idle_no_rd", fifo_rd, 0);
    chk("rst_mid_fifo_left", fifo_q.size(), 2);
    reset = 1'b0;
    resp_en = 1'b1;
    exp_frames = 1;
    exp_bad = 1'b0;
    exp_q.push_back('{t: 3, d: 8'h99});
    wait_idle(100);
    chk("rst_leftover_frame_cnt", frame_cnt, 1);
    // random frames, random ack latency, ack noise and FIFO gaps
    dmax = 3;
    noise = 1'b1;
    stall_pct = 25;
    for (int f = 0; f < 40; f++) begin
      h = {4'($urandom_range(0, 5)), 4'($urandom)};
      fill_rand(h);
      send_frame(h);
    end
    wait_idle(20000);
    chk("rand_frame_cnt", frame_cnt, 16'(exp_frames));
    chk("rand_err_bad", err_bad_tgt, exp_bad);
    chk("rand_err_to", err_timeout, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
